// File: rtl/led_blink_driver.sv
// Turns one-cycle event pulses into visible LED blinks (ON phase + dark GAP), queueing extra events.
// Define LED_DIM_EN to PWM-dim the LED during the ON phase.
module led_blink_driver #(
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned PEND_W     = 4,
    parameter int unsigned DIM_PERIOD = 16,
    parameter int unsigned DIM_DUTY   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned CntMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0]   OnLast  = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0]   OffLast = CntW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = '1;

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PEND_W < 1 || DIM_PERIOD < 2 || DIM_DUTY < 1 ||
        DIM_DUTY > DIM_PERIOD) begin : g_bad_params
        $error("led_blink_driver: invalid parameter set");
    end

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              want;
    logic              start;

    assign want = (pend_q != '0) || event_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // The last GAP cycle can chain straight into the next blink, so there is no idle bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (want) begin
                    state_d = StOn;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            StOn: begin
                if (cnt_q == OnLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == OffLast) begin
                    cnt_d = '0;
                    if (want) begin
                        state_d = StOn;
                        start   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // A start without a same-cycle event implies pend_q > 0, so the decrement never wraps.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (event_in && !start) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!event_in && start) begin
            pend_d = pend_q - 1'b1;
        end
    end

`ifdef LED_DIM_EN
    localparam int unsigned PwmW = $clog2(DIM_PERIOD);
    localparam logic [PwmW-1:0] PwmLast = PwmW'(DIM_PERIOD - 1);
    localparam logic [PwmW:0]   Duty    = (PwmW + 1)'(DIM_DUTY);

    logic [PwmW-1:0] pwm_q, pwm_d;

    // Zeroed on every blink start so each blink begins lit.
    always_comb begin
        pwm_d = '0;
        if (state_d == StOn && !start) begin
            pwm_d = (pwm_q == PwmLast) ? '0 : pwm_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    always_comb begin
        busy_d = (state_d != StIdle);
        led_d  = (state_d == StOn);
`ifdef LED_DIM_EN
        led_d  = led_d && ({1'b0, pwm_d} < Duty);
`endif
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Scoreboard bench for led_blink_driver: a timing-arithmetic model predicts outputs per cycle,
// a monitor compares them against the DUT one step later.
module tb_led_blink_driver;

    localparam int ON      = 4;
    localparam int OFF     = 2;
    localparam int PW      = 2;
    localparam int DP      = 4;
    localparam int DD      = 1;
    localparam int PendMax = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          event_in = 1'b0;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    always #5 clk = ~clk;

    led_blink_driver #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PW),
        .DIM_PERIOD(DP),
        .DIM_DUTY  (DD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .event_in(event_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    typedef struct {
        int   t;
        logic led;
        logic busy;
        int   pending;
        logic ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   drv_done = 0;

    // Model state: request count, sticky drop flag and the cycle of the latest blink start.
    int   t = 0;
    bit   has_blink = 0;
    int   last_start = 0;
    int   q = 0;
    bit   ovf = 0;

    task automatic step(input logic ev, input logic rst);
        exp_t e;
        int   d;
        bit   start;
        @(negedge clk);
        event_in = ev;
        reset    = rst;
        if (rst) begin
            has_blink = 0;
            q         = 0;
            ovf       = 0;
        end else begin
            start = (!has_blink || (t - last_start) >= ON + OFF) && (q > 0 || ev);
            if (ev && !start) begin
                if (q == PendMax) ovf = 1;
                else q++;
            end else if (!ev && start) begin
                q--;
            end
            if (start) begin
                has_blink  = 1;
                last_start = t;
            end
        end
        e.t       = t;
        e.pending = q;
        e.ovf     = ovf;
        e.led     = 1'b0;
        e.busy    = 1'b0;
        if (has_blink) begin
            d      = t - last_start;
            e.busy = (d < ON + OFF);
            e.led  = (d < ON);
`ifdef LED_DIM_EN
            e.led  = e.led && ((d % DP) < DD);
`endif
        end
        sb.push_back(e);
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                       input int tt);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", name, tt, got, exp);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    exp_t me;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("led", {31'b0, led}, {31'b0, me.led}, me.t);
                chk("busy", {31'b0, busy}, {31'b0, me.busy}, me.t);
                chk("pending", {30'b0, pending}, me.pending, me.t);
                chk("overflow", {31'b0, overflow}, {31'b0, me.ovf}, me.t);
            end
        end
    end

    initial begin
        int dens;
        repeat (3) step(0, 1);
        repeat (7) step(0, 0);
        // single event
        step(1, 0);
        repeat (20) step(0, 0);
        // three back-to-back events
        repeat (3) step(1, 0);
        repeat (30) step(0, 0);
        // saturate the queue during ON
        step(1, 0);
        step(0, 0);
        repeat (5) step(1, 0);
        repeat (40) step(0, 0);
        // event on the last GAP cycle
        step(1, 0);
        repeat (ON + OFF - 1) step(0, 0);
        step(1, 0);
        repeat (20) step(0, 0);
        // reset mid-ON with a populated queue and sticky overflow
        repeat (3) step(1, 0);
        step(0, 0);
        step(0, 1);
        repeat (6) step(0, 0);
        step(1, 0);
        repeat (20) step(0, 0);
        // random traffic at varying densities
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(0, 100);
            repeat (200) step($urandom_range(0, 99) < dens, $urandom_range(0, 399) == 0);
        end
        repeat (20) step(0, 0);
        drv_done = 1;
    end

    initial begin
        wait (drv_done);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        summary();
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before stimulus completed");
        summary();
        $finish;
    end

endmodule
